// File: rtl/cpu_defs_pkg.sv
// Shared constants for the P5 MIPS core front end.
// Word alignment helper clears the byte-offset bits of a byte address.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter flop: synchronous reset, stall hold, redirect load,
// otherwise sequential advance by one word.
module pc_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] npc,
    input  logic [31:0] pc4,
    output logic [31:0] pc
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;

    // Next-PC select; stall outranks redirect so a frozen pipe never jumps.
    always_comb begin
        pc_next_s = pc_r;
        if (stall) begin
            pc_next_s = pc_r;
        end else if (redirect) begin
            pc_next_s = word_align(npc);
        end else begin
            pc_next_s = pc4;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction-memory address, IF/ID register
// and fetch counter. Redirects keep the delay-slot word already in IF.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      npc,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             id_oob,
    output logic [31:0]      fetch_cnt
);

    // 33 bits so the capacity in bytes cannot overflow for wide IM_AW.
    localparam logic [32:0] IM_BYTES = {1'b0, WORD_BYTES} << IM_AW;

    logic [31:0] pc_s;
    logic [31:0] pc4_s;
    logic [31:0] offset_s;
    logic        oob_s;
    logic [31:0] fetch_word_s;

    logic [31:0] id_instr_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc4_r;
    logic        id_valid_r;
    logic        id_oob_r;
    logic [31:0] fetch_cnt_r;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .redirect(redirect),
        .npc     (npc),
        .pc4     (pc4_s),
        .pc      (pc_s)
    );

    assign pc4_s     = pc_s + WORD_BYTES;
    assign offset_s  = pc_s - RESET_PC;
    assign imem_addr = offset_s[IM_AW+1:2];

    // Out-of-range fetches (including below the base, which wraps high) become NOPs.
    always_comb begin
        oob_s        = 1'b0;
        fetch_word_s = INSTR_NOP;
        if ({1'b0, offset_s} < IM_BYTES) begin
            oob_s        = 1'b0;
            fetch_word_s = imem_rdata;
        end else begin
            oob_s        = 1'b1;
            fetch_word_s = INSTR_NOP;
        end
    end

    // IF/ID pipeline register and committed-fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr_r  <= INSTR_NOP;
            id_pc_r     <= 32'h0000_0000;
            id_pc4_r    <= 32'h0000_0000;
            id_valid_r  <= 1'b0;
            id_oob_r    <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else if (!stall) begin
            id_instr_r  <= fetch_word_s;
            id_pc_r     <= pc_s;
            id_pc4_r    <= pc4_s;
            id_valid_r  <= 1'b1;
            id_oob_r    <= oob_s;
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end else begin
            id_instr_r  <= id_instr_r;
            id_pc_r     <= id_pc_r;
            id_pc4_r    <= id_pc4_r;
            id_valid_r  <= id_valid_r;
            id_oob_r    <= id_oob_r;
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

    assign pc        = pc_s;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign id_pc4    = id_pc4_r;
    assign id_valid  = id_valid_r;
    assign id_oob    = id_oob_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction-memory model
// holding word k = 32'hA500_0000 + k.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] npc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        id_oob;
    logic [31:0] fetch_cnt;

    logic [31:0] mem [0:1023];

    int tests_run;
    int tests_failed;

    if_stage #(
        .RESET_PC(32'h0000_3000),
        .IM_AW   (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .redirect  (redirect),
        .npc       (npc),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .pc        (pc),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_pc4    (id_pc4),
        .id_valid  (id_valid),
        .id_oob    (id_oob),
        .fetch_cnt (fetch_cnt)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares every observable against hand-computed values after a step.
    task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_id_pc,
                                input logic [31:0] e_instr, input logic e_valid, input logic e_oob,
                                input logic [31:0] e_cnt);
        tests_run++;
        if (pc !== e_pc) begin
            tests_failed++;
            $display("FAIL %s pc: got %h expected %h", tag, pc, e_pc);
        end
        tests_run++;
        if (id_pc !== e_id_pc) begin
            tests_failed++;
            $display("FAIL %s id_pc: got %h expected %h", tag, id_pc, e_id_pc);
        end
        tests_run++;
        if (id_pc4 !== (e_valid ? e_id_pc + 32'd4 : 32'd0)) begin
            tests_failed++;
            $display("FAIL %s id_pc4: got %h expected %h", tag, id_pc4, e_valid ? e_id_pc + 32'd4 : 32'd0);
        end
        tests_run++;
        if (id_instr !== e_instr) begin
            tests_failed++;
            $display("FAIL %s id_instr: got %h expected %h", tag, id_instr, e_instr);
        end
        tests_run++;
        if (id_valid !== e_valid) begin
            tests_failed++;
            $display("FAIL %s id_valid: got %b expected %b", tag, id_valid, e_valid);
        end
        tests_run++;
        if (id_oob !== e_oob) begin
            tests_failed++;
            $display("FAIL %s id_oob: got %b expected %b", tag, id_oob, e_oob);
        end
        tests_run++;
        if (fetch_cnt !== e_cnt) begin
            tests_failed++;
            $display("FAIL %s fetch_cnt: got %0d expected %0d", tag, fetch_cnt, e_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; npc = 32'h0;
        step();
        step();
        expect_state("reset_hold", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        #1;
        expect_state("reset_release", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tests_run++;
        if (imem_addr !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, 10'd0);
        end
    endtask

    task automatic test_sequential();
        step();
        expect_state("seq1", 32'h3004, 32'h3000, 32'hA500_0000, 1'b1, 1'b0, 32'd1);
        step();
        expect_state("seq2", 32'h3008, 32'h3004, 32'hA500_0001, 1'b1, 1'b0, 32'd2);
        tests_run++;
        if (imem_addr !== 10'd2) begin
            tests_failed++;
            $display("FAIL seq_imem_addr: got %h expected %h", imem_addr, 10'd2);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("stall_hold", 32'h3008, 32'h3004, 32'hA500_0001, 1'b1, 1'b0, 32'd2);
        end
        stall = 1'b0;
        step();
        expect_state("stall_resume", 32'h300C, 32'h3008, 32'hA500_0002, 1'b1, 1'b0, 32'd3);
        step();
        expect_state("stall_next", 32'h3010, 32'h300C, 32'hA500_0003, 1'b1, 1'b0, 32'd4);
    endtask

    task automatic test_redirect();
        redirect = 1'b1; npc = 32'h3040;
        step();
        expect_state("redir_slot", 32'h3040, 32'h3010, 32'hA500_0004, 1'b1, 1'b0, 32'd5);
        redirect = 1'b0;
        step();
        expect_state("redir_target", 32'h3044, 32'h3040, 32'hA500_0010, 1'b1, 1'b0, 32'd6);
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect = 1'b1; npc = 32'h3080;
        step();
        expect_state("stall_prio", 32'h3044, 32'h3040, 32'hA500_0010, 1'b1, 1'b0, 32'd6);
        stall = 1'b0; npc = 32'h3103;
        step();
        expect_state("npc_align", 32'h3100, 32'h3044, 32'hA500_0011, 1'b1, 1'b0, 32'd7);
        redirect = 1'b0;
    endtask

    task automatic test_oob();
        redirect = 1'b1; npc = 32'h2FFC;
        step();
        expect_state("oob_below_pc", 32'h2FFC, 32'h3100, 32'hA500_0040, 1'b1, 1'b0, 32'd8);
        npc = 32'h4000;
        step();
        expect_state("oob_below_id", 32'h4000, 32'h2FFC, 32'h0, 1'b1, 1'b1, 32'd9);
        redirect = 1'b0;
        step();
        expect_state("oob_above_id", 32'h4004, 32'h4000, 32'h0, 1'b1, 1'b1, 32'd10);
        redirect = 1'b1; npc = 32'h3FFC;
        step();
        expect_state("oob_above2", 32'h3FFC, 32'h4004, 32'h0, 1'b1, 1'b1, 32'd11);
        redirect = 1'b0;
        step();
        expect_state("last_word", 32'h4000, 32'h3FFC, 32'hA500_03FF, 1'b1, 1'b0, 32'd12);
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; npc = 32'h3200; reset = 1'b1;
        step();
        expect_state("mid_reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0; redirect = 1'b0;
        step();
        expect_state("after_reset", 32'h3004, 32'h3000, 32'hA500_0000, 1'b1, 1'b0, 32'd1);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'hA500_0000 + k;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_oob();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
